id_ex_skid_reg: RTL and testbench

Parametrised successor to the decode-stage pipeline register; sits between the instruction-decode stage and the execute stage. Replaces the single flop bank with a two-entry valid/ready skid buffer. Downstream back-pressure (multi-cycle mul, memory wait) therefore no longer forces a global stall. Adds hazard gating, flush-to-NOP, occupancy and saturating bubble/flush counters.

---
 rtl/id_ex_skid_reg_pkg.sv | 33 +++
 rtl/id_ex_skid_reg_sat_counter.sv | 27 ++
 rtl/id_ex_skid_reg.sv | 98 +++++++++
 tb/tb_id_ex_skid_reg.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_reg_pkg.sv
// Shared constants for the ID/EX skid register: control-bit indices, default widths,
// payload field offsets and the occupancy state encoding.
package id_ex_skid_reg_pkg;

  localparam int DEF_CTRL_W   = 7;
  localparam int DEF_DATA_W   = 138;
  localparam int DEF_STATUS_W = 4;
  localparam int DEF_CNT_W    = 16;

  localparam int CTRL_MEM_R = 0;
  localparam int CTRL_MEM_W = 1;
  localparam int CTRL_WB    = 2;
  localparam int CTRL_IMM   = 3;
  localparam int CTRL_BR    = 4;
  localparam int CTRL_SWE   = 5;
  localparam int CTRL_MUL   = 6;

  // Payload layout, LSB first; the shift operand takes the remaining upper bits.
  localparam int PC_LSB    = 0;
  localparam int OP1_LSB   = 32;
  localparam int OP2_LSB   = 64;
  localparam int DEST_LSB  = 96;
  localparam int EXE_LSB   = 100;
  localparam int SIMM_LSB  = 104;
  localparam int SHIFT_LSB = 128;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/id_ex_skid_reg_sat_counter.sv
// Saturating up-counter used for the bubble and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// Decode-to-execute pipeline register as a two-entry valid/ready skid buffer with
// hazard gating, flush-to-NOP and saturating bubble/flush counters.
module id_ex_skid_reg
  import id_ex_skid_reg_pkg::*;
#(
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int STATUS_W = DEF_STATUS_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hazard,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STATUS_W-1:0] in_status,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_data,
  output logic [STATUS_W-1:0] out_status,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    bubble_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]   ctrl;
    logic [DATA_W-1:0]   data;
    logic [STATUS_W-1:0] status;
  } ent_t;

  occ_e st_q, st_d;
  ent_t head_q, head_d, skid_q, skid_d, in_ent;
  logic accept, fire;

  // The skid slot is occupied exactly in ST_FULL, so in_ready never sees out_ready.
  assign in_ready = (st_q != ST_FULL) & ~hazard;
  assign out_valid = (st_q != ST_EMPTY);
  assign accept = in_valid & in_ready & ~flush;
  assign fire = out_valid & out_ready;
  assign in_ent = '{ctrl: in_ctrl, data: in_data, status: in_status};

  always_comb begin
    st_d   = st_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      st_d = ST_EMPTY;
    end else begin
      case (st_q)
        ST_EMPTY: if (accept) begin st_d = ST_ONE; head_d = in_ent; end
        ST_ONE: begin
          if (fire && accept) head_d = in_ent;
          else if (fire)      st_d = ST_EMPTY;
          else if (accept)    begin st_d = ST_FULL; skid_d = in_ent; end
        end
        ST_FULL:  if (fire) begin st_d = ST_ONE; head_d = skid_q; end
        default:  st_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= ST_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      st_q   <= st_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign out_ctrl   = out_valid ? head_q.ctrl : '0;
  assign out_data   = head_q.data;
  assign out_status = head_q.status;
  assign occupancy  = st_q;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (out_ready & ~out_valid),
    .cnt_o  (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .inc_i  (flush & (st_q != ST_EMPTY)),
    .cnt_o  (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Scoreboard bench for id_ex_skid_reg: model tracks occupancy, expected entries and counters.
module tb_id_ex_skid_reg;
  import id_ex_skid_reg_pkg::*;

  localparam int CW = 7, DW = 138, SW = 4, NW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush, hazard, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [SW-1:0] in_status, out_status;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt, flush_cnt;

  id_ex_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .STATUS_W(SW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hazard(hazard),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .in_status(in_status), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_status(out_status),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance, idle, used only for the saturation check.
  logic          b_flush, b_hazard, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [SW-1:0] b_in_status, b_out_status;
  logic [1:0]    b_occ, b_bub, b_fl;

  id_ex_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .STATUS_W(SW), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(b_flush), .hazard(b_hazard),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .in_status(b_in_status), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_status(b_out_status),
    .occupancy(b_occ), .bubble_cnt(b_bub), .flush_cnt(b_fl)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } ent_t;

  ent_t q[$];
  int   m_occ, m_bub, m_fl;
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Checks the state the model predicts, then advances the model with this cycle's inputs.
  always @(negedge clk) begin : mon
    ent_t hd, ne;
    logic exp_vld, exp_rdy, acc, fir;
    if (!rst) begin
      q.delete();
      m_occ = 0; m_bub = 0; m_fl = 0;
      chk("rst_vld", out_valid, 0);
      chk("rst_ctrl", out_ctrl, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_bub", bubble_cnt, 0);
      chk("rst_fl", flush_cnt, 0);
      chk("rst_rdy", in_ready, !hazard);
    end else begin
      exp_vld = (m_occ != 0);
      exp_rdy = (m_occ != 2) && !hazard;
      hd = (q.size() > 0) ? q[0] : '0;
      chk("vld", out_valid, exp_vld);
      chk("rdy", in_ready, exp_rdy);
      chk("occ", occupancy, m_occ);
      chk("bub", bubble_cnt, m_bub);
      chk("fl", flush_cnt, m_fl);
      chk("ctrl", out_ctrl, exp_vld ? hd.c : '0);
      fir = exp_vld && out_ready;
      acc = in_valid && exp_rdy && !flush;
      if (fir) begin
        chk("data", out_data, hd.d);
        chk("stat", out_status, hd.s);
        void'(q.pop_front());
      end
      if (out_ready && !exp_vld && m_bub < 65535) m_bub++;
      if (flush) begin
        if (m_occ != 0 && m_fl < 65535) m_fl++;
        q.delete();
        m_occ = 0;
      end else begin
        if (acc) begin
          ne.c = in_ctrl; ne.d = in_data; ne.s = in_status;
          q.push_back(ne);
        end
        m_occ = q.size();
      end
    end
  end

  task automatic drv(input logic v, input logic [31:0] pc, input logic hz,
                     input logic ordy, input logic fl);
    logic [159:0] r;
    @(posedge clk); #1;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r[31:0] = pc;
    in_valid  = v;
    in_data   = r[DW-1:0];
    in_ctrl   = CW'($urandom());
    in_status = SW'($urandom());
    hazard    = hz;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; hazard = 1; in_valid = 0; out_ready = 0;
    in_ctrl = '0; in_data = '0; in_status = '0;
    b_flush = 0; b_hazard = 0; b_in_valid = 0; b_out_ready = 0;
    b_in_ctrl = '0; b_in_data = '0; b_in_status = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 hazard = 0;
    @(posedge clk); #1 rst = 1'b1;

    // streaming at full rate
    drv(1, 32'h0, 0, 1, 0); drv(1, 32'h4, 0, 1, 0);
    drv(1, 32'h8, 0, 1, 0); drv(1, 32'hC, 0, 1, 0);
    drv(0, 32'h0, 0, 1, 0);

    // back-pressure fills the skid slot, then drains in order
    drv(1, 32'h10, 0, 0, 0); drv(1, 32'h14, 0, 0, 0); drv(1, 32'h99, 0, 0, 0);
    drv(0, 32'h0, 0, 1, 0); drv(0, 32'h0, 0, 1, 0); drv(0, 32'h0, 0, 1, 0);

    // flush while full with an incoming instruction
    drv(1, 32'h20, 0, 0, 0); drv(1, 32'h24, 0, 0, 0);
    drv(1, 32'h18, 0, 0, 1);
    drv(0, 32'h0, 0, 1, 0);
    chk("flush_cnt_one", flush_cnt, 1);

    // hazard blocks acceptance while the held entry drains
    drv(1, 32'h30, 0, 1, 0);
    drv(1, 32'h34, 1, 1, 0); drv(1, 32'h34, 1, 1, 0); drv(1, 32'h34, 1, 1, 0);
    drv(0, 32'h0, 0, 1, 0);

    // async reset while full
    drv(1, 32'h40, 0, 0, 0); drv(1, 32'h44, 0, 0, 0);
    drv(0, 32'h0, 0, 0, 0);
    #1 rst = 1'b0; hazard = 1;
    @(posedge clk); #1 hazard = 0;
    @(posedge clk); #1 rst = 1'b1;

    // narrow counter saturates
    b_out_ready = 1;
    repeat (6) @(posedge clk);
    #1 chk("sat_bub", b_bub, 3);

    // random traffic
    for (int i = 0; i < 300; i++)
      drv(($urandom() % 4) != 0, 32'h100 + 32'(i * 4), ($urandom() % 8) == 0,
          ($urandom() % 3) != 0, ($urandom() % 32) == 0);
    drv(0, 32'h0, 0, 1, 0); drv(0, 32'h0, 0, 1, 0); drv(0, 32'h0, 0, 1, 0);
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
